wide_add_arbiter: RTL and testbench
===================================

// Module: wide_add_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one carry-select wide adder
//  (WIDTH-bit, en pulse in, en_out pulse out) between NUM_REQ requesters.
//  Latches the winner's operands, holds them stable for the adder's
//  two-pass (cin=0/cin=1) evaluation, captures the sum and returns it.
// PARAMETERS
//  NUM_REQ  4     number of requesters (2..8)
//  WIDTH    3200  operand/result width; must match the adder (128*25)
//  TIMEOUT  8     max WAIT cycles before abort (only with ADD_ARB_TIMEOUT_EN)
// PORTS
//  clk         in   1               clock
//  rst_n       in   1               synchronous, active-low reset
//  req         in   NUM_REQ         per-requester request level
//  req_a       in   NUM_REQ*WIDTH   operand A, slice i = requester i
//  req_b       in   NUM_REQ*WIDTH   operand B, slice i = requester i
//  gnt         out  NUM_REQ         one-hot 1-cycle pulse: operands accepted
//  done        out  NUM_REQ         one-hot 1-cycle pulse: result valid
//  result      out  WIDTH           sum (a+b) mod 2^WIDTH, held until next done
//  err         out  1               high with done if op was aborted
//  busy        out  1               high in any state other than IDLE
//  add_a       out  WIDTH           to adder a (registered, held stable)
//  add_b       out  WIDTH           to adder b (registered, held stable)
//  add_en      out  1               to adder en, 1-cycle pulse
//  add_c       in   WIDTH           from adder c
//  add_en_out  in   1               from adder en_out
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = NUM_REQ-1 (req[0] wins first).
//  Reset must be shared with the adder; reset mid-op discards the op, no done.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE:
//   IDLE: if |req, pick first set bit searching from ptr+1 (wrap mod NUM_REQ);
//         latch req_a/req_b slices into add_a/add_b, owner<=idx, ptr<=idx.
//   ISSUE (1 cycle): gnt[owner]=1, add_en=1.
//   WAIT: add_en=0; add_a/add_b unchanged. add_en_out=1 -> latch add_c into
//         result -> RESP. Nominally 3 cycles in WAIT.
//   RESP (1 cycle): done[owner]=1, err as set; then IDLE.
//  Latency: req sampled at edge t0 -> gnt during cycle after t0 -> done 4
//   cycles after gnt. Throughput: 1 op per 6 cycles.
//  Requester holds req and operands stable until it sees gnt; it may then
//   drop req/change operands freely. req re-asserted during RESP is
//   arbitrated in the following IDLE cycle.
//  add_en is never pulsed outside ISSUE (adder must not be re-enabled mid-op).
//  add_en_out seen in IDLE/ISSUE/RESP: ignored.
//  Carry out of bit WIDTH-1 is dropped (modulo result); no overflow flag.
//  gnt, done: at most one bit set; never both in the same cycle.
// CONFIGURATION
//  ADD_ARB_TIMEOUT_EN defined: WAIT cycle counter; at TIMEOUT cycles without
//   add_en_out -> RESP with err=1, result=0. Counter clears on entering WAIT.
//  Not defined: WAIT waits indefinitely; err tied 0; no counter logic.
// TESTING
//  1. req=0001, a0=5, b0=7 -> gnt=0001 1 cycle later, done=0001 after 4 more,
//     result=12, err=0.
//  2. req=0101 held from reset -> grant order 0,2,0,2; each done on own bit.
//  3. a=all ones, b=1 -> result=0 (full carry chain, carry dropped);
//     a=2^128-1, b=1 -> result=2^128.
//  4. req=1111 continuously -> grants 0,1,2,3,0; 6-cycle spacing; no add_en
//     while busy.
//  5. Stub adder never raises en_out, macro on -> done after TIMEOUT, err=1,
//     result=0; macro off -> busy stays 1.
//  6. rst_n=0 in WAIT -> next cycle all outputs 0, no done; new req served
//     normally, starting at requester 0.

Source files
------------

// File: rtl/wide_add_arbiter.sv
// Round-robin arbiter/sequencer sharing one two-pass wide adder among NUM_REQ requesters.
// Latency: gnt one cycle after req is sampled in IDLE, done 4 cycles after gnt; 1 op per 6 cycles.
// Backpressure: requesters hold req/operands until gnt; optional WAIT timeout via ADD_ARB_TIMEOUT_EN.
module wide_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 3200,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic                     err,
  output logic                     busy,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_en,
  input  logic [WIDTH-1:0]         add_c,
  input  logic                     add_en_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   w_pick;
  logic [IDX_W-1:0]   w_j;
  logic               w_any;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;
  logic [WIDTH-1:0]   r_result;
  logic               w_timeout;

`ifdef ADD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
`endif

  // Round-robin pick: first set request searching upward from the slot after the last winner.
  always_comb begin
    w_pick = '0;
    w_j    = '0;
    w_any  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_any && req[w_j]) begin
        w_any  = 1'b1;
        w_pick = w_j;
      end
    end
  end

  // Abort condition for a WAIT that never sees the adder's completion pulse.
`ifdef ADD_ARB_TIMEOUT_EN
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state logic for the IDLE->ISSUE->WAIT->RESP sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (add_en_out || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; a reset mid-operation simply drops the op.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Winner capture: operands are latched once and held stable across both adder passes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_owner <= '0;
      r_add_a <= '0;
      r_add_b <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_ptr   <= w_pick;
      r_owner <= w_pick;
      r_add_a <= req_a[w_pick*WIDTH +: WIDTH];
      r_add_b <= req_b[w_pick*WIDTH +: WIDTH];
    end
  end

`ifdef ADD_ARB_TIMEOUT_EN
  // Result capture; an aborted op returns zero with the error flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (r_state == S_WAIT) begin
      if (add_en_out) begin
        r_result <= add_c;
        r_err    <= 1'b0;
      end else if (w_timeout) begin
        r_result <= '0;
        r_err    <= 1'b1;
      end
    end
  end

  // WAIT cycle counter, cleared while issuing so each op starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n)                   r_cnt <= '0;
    else if (r_state == S_ISSUE)  r_cnt <= '0;
    else if (r_state == S_WAIT)   r_cnt <= r_cnt + 1'b1;
  end

  assign err = (r_state == S_RESP) && r_err;
`else
  // Result capture on the adder's completion pulse; late pulses outside WAIT are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n)                              r_result <= '0;
    else if (r_state == S_WAIT && add_en_out) r_result <= add_c;
  end

  assign err = 1'b0;
`endif

  assign w_owner_oh = NUM_REQ'(1) << r_owner;
  assign gnt        = (r_state == S_ISSUE) ? w_owner_oh : '0;
  assign done       = (r_state == S_RESP)  ? w_owner_oh : '0;
  assign add_en     = (r_state == S_ISSUE);
  assign busy       = (r_state != S_IDLE);
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign result     = r_result;

endmodule

// File: tb/tb_wide_add_arbiter.sv
// Directed bench for wide_add_arbiter with a 3-cycle stub adder.
// Latency/order/boundary checks use hand-computed expected values.
// Stub completion can be disabled to exercise the timeout/hang path.
module tb_wide_add_arbiter;
  localparam int N  = 4;
  localparam int W  = 3200;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           err;
  logic           busy;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_en;
  logic [W-1:0]   add_c;
  logic           add_en_out;

  logic [2:0]     r_pipe;
  bit             stub_on = 1'b1;
  int             cyc = 0;
  int             n_done = 0;
  int             bad_en = 0;
  int             bad_both = 0;
  int             total = 0;
  int             bad = 0;

  always #5 clk = ~clk;

  wide_add_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_en(add_en),
    .add_c(add_c), .add_en_out(add_en_out)
  );

  // Stub adder: en_out three cycles after en, sum of the held operands.
  always @(posedge clk) begin
    if (!rst_n) r_pipe <= 3'b000;
    else        r_pipe <= {r_pipe[1:0], add_en & stub_on};
  end
  assign add_en_out = r_pipe[2];
  assign add_c      = add_a + add_b;

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|done) n_done <= n_done + 1;
      if (add_en && gnt == '0) bad_en <= bad_en + 1;
      if ((|gnt) && (|done)) bad_both <= bad_both + 1;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got hi=%h lo=%h want hi=%h lo=%h", tag,
               obs[W-1 -: 32], obs[159:0], exp[W-1 -: 32], exp[159:0]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_gnt(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick;
      if (|gnt) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick;
      if (|done) ok = 1'b1;
    end
  endtask

  initial begin
    bit           ok;
    int           g;
    int           last_g;
    int           nd;
    logic [W-1:0] tmp;
    logic [W-1:0] expv;
    logic [N-1:0] ord2 [4];
    logic [N-1:0] ord4 [5];

    req_a = '0;
    req_b = '0;
    req   = '0;
    rst_n = 1'b0;
    do_reset;

    // Reset state
    chk("rst_gnt",    W'(gnt),    W'(0));
    chk("rst_done",   W'(done),   W'(0));
    chk("rst_busy",   W'(busy),   W'(0));
    chk("rst_add_en", W'(add_en), W'(0));
    chk("rst_err",    W'(err),    W'(0));
    chk("rst_result", result,     W'(0));
    chk("rst_add_a",  add_a,      W'(0));

    // 1: single op 5+7, exact latency
    set_op(0, W'(5), W'(7));
    req = 4'b0001;
    tick;
    chk("t1_gnt",    W'(gnt),    W'(4'b0001));
    chk("t1_add_en", W'(add_en), W'(1));
    chk("t1_add_a",  add_a,      W'(5));
    req = '0;
    tick; tick; tick;
    chk("t1_done_early", W'(done), W'(0));
    chk("t1_add_b_held", add_b,    W'(7));
    tick;
    chk("t1_done",   W'(done), W'(4'b0001));
    chk("t1_result", result,   W'(12));
    chk("t1_err",    W'(err),  W'(0));
    tick;
    chk("t1_idle", W'(busy), W'(0));

    // 2: req=0101 held -> 0,2,0,2
    do_reset;
    set_op(0, W'(100), W'(1));
    set_op(2, W'(200), W'(2));
    ord2[0] = 4'b0001; ord2[1] = 4'b0100; ord2[2] = 4'b0001; ord2[3] = 4'b0100;
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(12, ok);
      chk("t2_gnt_seen", W'(ok), W'(1));
      chk("t2_gnt", W'(gnt), W'(ord2[k]));
      wait_done(12, ok);
      chk("t2_done_seen", W'(ok), W'(1));
      chk("t2_done", W'(done), W'(ord2[k]));
      chk("t2_result", result, (k % 2 == 0) ? W'(101) : W'(202));
    end
    req = '0;
    wait_done(4, ok);

    // 3: carry-chain boundaries
    do_reset;
    set_op(0, '1, W'(1));
    req = 4'b0001;
    wait_gnt(12, ok);
    req = '0;
    wait_done(12, ok);
    chk("t3_wrap_seen", W'(ok), W'(1));
    chk("t3_wrap", result, W'(0));
    tmp = '0;
    tmp[127:0] = '1;
    expv = '0;
    expv[128] = 1'b1;
    set_op(0, tmp, W'(1));
    req = 4'b0001;
    wait_gnt(12, ok);
    req = '0;
    wait_done(12, ok);
    chk("t3_2p128", result, expv);

    // 4: all requesting -> 0,1,2,3,0 at 6-cycle spacing
    do_reset;
    for (int i = 0; i < N; i++) set_op(i, W'(i + 1), W'(1000));
    ord4[0] = 4'b0001; ord4[1] = 4'b0010; ord4[2] = 4'b0100;
    ord4[3] = 4'b1000; ord4[4] = 4'b0001;
    req = 4'b1111;
    last_g = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(12, ok);
      chk("t4_gnt_seen", W'(ok), W'(1));
      chk("t4_gnt", W'(gnt), W'(ord4[k]));
      if (k > 0) chk("t4_gap", W'(cyc - last_g), W'(6));
      last_g = cyc;
    end
    req = '0;
    wait_done(12, ok);
    chk("t4_result", result, W'(1001));
    chk("t4_en_outside_issue", W'(bad_en),   W'(0));
    chk("t4_gnt_and_done",     W'(bad_both), W'(0));

    // 5: adder never completes
    do_reset;
    set_op(0, W'(3), W'(4));
    req = 4'b0001;
    wait_gnt(12, ok);
    req = '0;
    wait_done(12, ok);
    chk("t5_pre_result", result, W'(7));
    stub_on = 1'b0;
    req = 4'b0001;
    wait_gnt(12, ok);
    g = cyc;
    req = '0;
`ifdef ADD_ARB_TIMEOUT_EN
    wait_done(TO + 10, ok);
    chk("t5_to_seen",   W'(ok),      W'(1));
    chk("t5_to_gap",    W'(cyc - g), W'(TO + 1));
    chk("t5_to_done",   W'(done),    W'(4'b0001));
    chk("t5_to_err",    W'(err),     W'(1));
    chk("t5_to_result", result,      W'(0));
`else
    nd = n_done;
    repeat (30) tick;
    chk("t5_hang_busy", W'(busy),   W'(1));
    chk("t5_hang_done", W'(n_done), W'(nd));
`endif
    stub_on = 1'b1;

    // 6: reset in WAIT discards the op; pointer restarts at requester 0
    do_reset;
    set_op(2, W'(9), W'(9));
    req = 4'b0100;
    wait_gnt(12, ok);
    chk("t6_gnt2", W'(gnt), W'(4'b0100));
    req = '0;
    tick;
    rst_n = 1'b0;
    tick;
    chk("t6_rst_busy",   W'(busy),   W'(0));
    chk("t6_rst_gnt",    W'(gnt),    W'(0));
    chk("t6_rst_done",   W'(done),   W'(0));
    chk("t6_rst_add_a",  add_a,      W'(0));
    chk("t6_rst_add_en", W'(add_en), W'(0));
    rst_n = 1'b1;
    nd = n_done;
    repeat (6) tick;
    chk("t6_no_done", W'(n_done), W'(nd));
    for (int i = 0; i < N; i++) set_op(i, W'(20 + i), W'(1));
    req = 4'b1111;
    wait_gnt(12, ok);
    chk("t6_restart_gnt", W'(gnt), W'(4'b0001));
    req = '0;
    wait_done(12, ok);
    chk("t6_restart_done",   W'(done), W'(4'b0001));
    chk("t6_restart_result", result,   W'(21));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hung run, want completion");
    $fatal(1);
  end

endmodule
